// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single-port data memory between the CPU load/store path and an
//   external requester (loader / debug / DMA). The CPU wins by default; a
//   starvation counter forces EXT in after STARVE_LIMIT denied cycles, and a
//   locked burst lets EXT keep the port for up to MAX_BURST beats.
//
// Ports
//   clk, reset                 clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata      CPU request side
//   cpu_gnt, cpu_stall         CPU issued this cycle / CPU denied (PC hold)
//   cpu_rvalid, cpu_rdata      CPU load return, one cycle after issue
//   ext_req/we/lock/addr/wdata EXT request side (lock = keep port next beat)
//   ext_gnt                    EXT issued this cycle
//   ext_rvalid, ext_rdata      EXT read return, one cycle after issue
//   mem_addr/wdata/w_en/read_en  to dmem
//   mem_rdata                  from dmem, valid one cycle after read issue
//
// States
//   state      | meaning
//   CPU_PRI    | default: CPU first, EXT when CPU idle; counts EXT starvation
//   EXT_FORCED | EXT starved too long: EXT owns the port this cycle
//   EXT_BURST  | EXT holds the port for locked beats, up to MAX_BURST
module dmem_port_arbiter #(
    parameter int AW           = 30,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic          ext_lock,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_w_en,
    output logic          mem_read_en,
    input  logic [DW-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
    // A one-beat burst limit means a locked beat never needs the burst state.
    localparam logic BURST_OK = (MAX_BURST > 1);

    typedef enum logic [1:0] {
        CPU_PRI    = 2'd0,
        EXT_FORCED = 2'd1,
        EXT_BURST  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic [BW-1:0] beat_cnt, beat_nxt, beat_inc;
    logic          cpu_sel, ext_sel;
    logic          rd_valid_q, rd_owner_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= CPU_PRI;
            starve_cnt <= '0;
            beat_cnt   <= '0;
            rd_valid_q <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            beat_cnt   <= beat_nxt;
            rd_valid_q <= (cpu_sel & ~cpu_we) | (ext_sel & ~ext_we);
            rd_owner_q <= ext_sel;
        end
    end

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        beat_nxt   = beat_cnt;
        beat_inc   = beat_cnt + BW'(1);
        cpu_sel    = 1'b0;
        ext_sel    = 1'b0;
        case (state)
            CPU_PRI: begin
                beat_nxt = '0;
                if (cpu_req)      cpu_sel = 1'b1;
                else if (ext_req) ext_sel = 1'b1;

                if (ext_req && !ext_sel) begin
                    if (starve_cnt != STARVE_MAX) starve_nxt = starve_cnt + SW'(1);
                end else begin
                    starve_nxt = '0;
                end

                if (starve_nxt == STARVE_MAX) begin
                    state_nxt = EXT_FORCED;
                end else if (ext_sel && ext_lock && BURST_OK) begin
                    state_nxt = EXT_BURST;
                    beat_nxt  = BW'(1);
                end
            end
            EXT_FORCED: begin
                starve_nxt = '0;
                beat_nxt   = '0;
                state_nxt  = CPU_PRI;
                if (ext_req) begin
                    ext_sel = 1'b1;
                    if (ext_lock && BURST_OK) begin
                        state_nxt = EXT_BURST;
                        beat_nxt  = BW'(1);
                    end
                end else begin
                    // EXT went away while being forced in; don't waste the cycle.
                    cpu_sel = cpu_req;
                end
            end
            EXT_BURST: begin
                starve_nxt = '0;
                if (ext_req) begin
                    ext_sel  = 1'b1;
                    beat_nxt = beat_inc;
                    if (!ext_lock || beat_inc == BURST_MAX) begin
                        state_nxt = CPU_PRI;
                        beat_nxt  = '0;
                    end
                end else begin
                    cpu_sel   = cpu_req;
                    state_nxt = CPU_PRI;
                    beat_nxt  = '0;
                end
            end
            default: begin
                state_nxt  = CPU_PRI;
                starve_nxt = '0;
                beat_nxt   = '0;
            end
        endcase
    end

    // Grants are forced low while reset is held so dmem sees no access even
    // though the state register already sits in CPU_PRI. The registered read
    // tracking uses the ungated selects; those flops are held in reset anyway.
    assign cpu_gnt   = cpu_sel & reset;
    assign ext_gnt   = ext_sel & reset;
    assign cpu_stall = cpu_req & ~cpu_gnt;

    always_comb begin
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_w_en    = 1'b0;
        mem_read_en = 1'b0;
        if (cpu_gnt) begin
            mem_addr    = cpu_addr;
            mem_wdata   = cpu_wdata;
            mem_w_en    = cpu_we;
            mem_read_en = ~cpu_we;
        end else if (ext_gnt) begin
            mem_addr    = ext_addr;
            mem_wdata   = ext_wdata;
            mem_w_en    = ext_we;
            mem_read_en = ~ext_we;
        end
    end

    assign cpu_rvalid = rd_valid_q & ~rd_owner_q;
    assign ext_rvalid = rd_valid_q &  rd_owner_q;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign ext_rdata  = ext_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//   Bench for dmem_port_arbiter (STARVE_LIMIT=4, MAX_BURST=8). A small dmem
//   model answers reads one cycle after issue; a scoreboard queues the
//   expected return for every granted read and checks it the following cycle.
module tb_dmem_port_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt, cpu_stall, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          ext_req, ext_we, ext_lock;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_gnt, ext_rvalid;
    logic [DW-1:0] ext_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_w_en, mem_read_en;
    logic [DW-1:0] mem_rdata;

    typedef struct packed {
        logic          owner;   // 1 = EXT
        logic [DW-1:0] data;
    } rd_t;

    rd_t           sb[$];
    logic [DW-1:0] mem [256];
    int            n_checks;
    int            n_fail;

    dmem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4), .MAX_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w_en(mem_w_en),
        .mem_read_en(mem_read_en), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_init(input int a);
        return 32'hD000_0000 + a * 32'h0001_0101;
    endfunction

    task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cd, input logic er, input logic ew,
                         input logic el, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        ext_req = er; ext_we = ew; ext_lock = el; ext_addr = ea; ext_wdata = ed;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_model();
        forever begin
            @(posedge clk);
            if (mem_w_en)    mem[mem_addr[7:0]] <= mem_wdata;
            if (mem_read_en) mem_rdata <= mem[mem_addr[7:0]];
        end
    endtask

    task automatic monitor();
        rd_t           e;
        logic          ev_c, ev_e;
        logic [DW-1:0] ed_c, ed_e;
        logic [AW+DW+1:0] exp_mux;
        forever begin
            @(negedge clk);
            if (!reset) begin
                sb.delete();
                n_checks++;
                if ({cpu_gnt, ext_gnt, mem_w_en, mem_read_en, cpu_rvalid, ext_rvalid} !== 6'b0) begin
                    n_fail++;
                    $display("FAIL mon_reset_quiet: got %b required 000000",
                             {cpu_gnt, ext_gnt, mem_w_en, mem_read_en, cpu_rvalid, ext_rvalid});
                end
            end else begin
                ev_c = 1'b0; ev_e = 1'b0; ed_c = '0; ed_e = '0;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    if (e.owner) begin ev_e = 1'b1; ed_e = e.data; end
                    else         begin ev_c = 1'b1; ed_c = e.data; end
                end
                n_checks++;
                if ({cpu_rvalid, ext_rvalid} !== {ev_c, ev_e}) begin
                    n_fail++;
                    $display("FAIL sb_rvalid @%0t: got cpu/ext=%b required %b", $time,
                             {cpu_rvalid, ext_rvalid}, {ev_c, ev_e});
                end
                n_checks++;
                if (cpu_rdata !== ed_c) begin
                    n_fail++;
                    $display("FAIL sb_cpu_rdata @%0t: got %h required %h", $time, cpu_rdata, ed_c);
                end
                n_checks++;
                if (ext_rdata !== ed_e) begin
                    n_fail++;
                    $display("FAIL sb_ext_rdata @%0t: got %h required %h", $time, ext_rdata, ed_e);
                end
                n_checks++;
                if ((cpu_gnt & ext_gnt) !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mon_one_grant @%0t: got both granted required at most one", $time);
                end
                n_checks++;
                if (cpu_stall !== (cpu_req & ~cpu_gnt)) begin
                    n_fail++;
                    $display("FAIL mon_stall @%0t: got %b required %b", $time, cpu_stall,
                             cpu_req & ~cpu_gnt);
                end
                if (cpu_gnt)      exp_mux = {cpu_addr, cpu_wdata, cpu_we, ~cpu_we};
                else if (ext_gnt) exp_mux = {ext_addr, ext_wdata, ext_we, ~ext_we};
                else              exp_mux = '0;
                n_checks++;
                if ({mem_addr, mem_wdata, mem_w_en, mem_read_en} !== exp_mux) begin
                    n_fail++;
                    $display("FAIL mon_mem_mux @%0t: got %h required %h", $time,
                             {mem_addr, mem_wdata, mem_w_en, mem_read_en}, exp_mux);
                end
                if (cpu_gnt && !cpu_we) sb.push_back(rd_t'{owner: 1'b0, data: mem[cpu_addr[7:0]]});
                if (ext_gnt && !ext_we) sb.push_back(rd_t'{owner: 1'b1, data: mem[ext_addr[7:0]]});
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 30'h1, '0, 1'b1, 1'b0, 1'b1, 30'h2, '0);
        #2;
        n_checks++;
        if ({cpu_gnt, ext_gnt} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_gnt: got %b required 00", {cpu_gnt, ext_gnt});
        end
        n_checks++;
        if ({cpu_rvalid, ext_rvalid, mem_w_en, mem_read_en} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0000",
                     {cpu_rvalid, ext_rvalid, mem_w_en, mem_read_en});
        end
        n_checks++;
        if (cpu_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_stall: got %b required 1", cpu_stall);
        end
        @(posedge clk);
        idle();
        #3 reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle_mux: got %h/%h required 0/0", mem_addr, mem_wdata);
        end
        next_cycle();
    endtask

    task automatic test_cpu_only();
        drive(1'b1, 1'b0, 30'h10, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, ext_gnt, mem_read_en} !== 3'b101 || mem_addr !== 30'h10) begin
            n_fail++;
            $display("FAIL cpu_rd_issue: got gnt/ext/ren=%b addr=%h required 101 addr=010",
                     {cpu_gnt, ext_gnt, mem_read_en}, mem_addr);
        end
        next_cycle();
        drive(1'b1, 1'b1, 30'h20, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== mem_init(32'h10)) begin
            n_fail++;
            $display("FAIL cpu_rd_return: got v=%b d=%h required v=1 d=%h",
                     cpu_rvalid, cpu_rdata, mem_init(32'h10));
        end
        n_checks++;
        if ({mem_w_en, mem_read_en} !== 2'b10) begin
            n_fail++;
            $display("FAIL cpu_store_en: got %b required 10", {mem_w_en, mem_read_en});
        end
        next_cycle();
        drive(1'b1, 1'b0, 30'h20, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_store_no_rvalid: got %b required 0", cpu_rvalid);
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL cpu_readback: got v=%b d=%h required v=1 d=cafef00d", cpu_rvalid, cpu_rdata);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        logic [5:0] exp_ext;
        exp_ext = 6'b010000;   // bit i = EXT expected to own cycle i
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 30'h1, '0, 1'b1, 1'b0, 1'b0, 30'h2, '0);
            @(negedge clk);
            n_checks++;
            if ({cpu_gnt, ext_gnt, cpu_stall} !== {~exp_ext[i], exp_ext[i], exp_ext[i]}) begin
                n_fail++;
                $display("FAIL contention_c%0d: got cpu/ext/stall=%b required %b", i,
                         {cpu_gnt, ext_gnt, cpu_stall}, {~exp_ext[i], exp_ext[i], exp_ext[i]});
            end
            next_cycle();
        end
        idle();
        next_cycle();
    endtask

    task automatic test_burst();
        int   beats;
        logic exp_e;
        beats = 0;
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 1'b0, 30'h60 + 30'(i), '0, 1'b1, 1'b0, 1'b1, 30'h40 + 30'(i), '0);
            @(negedge clk);
            exp_e = (i >= 4 && i <= 11);   // 4 starved cycles, then 8 locked beats
            if (ext_gnt) beats++;
            n_checks++;
            if ({cpu_gnt, ext_gnt} !== {~exp_e, exp_e}) begin
                n_fail++;
                $display("FAIL burst_c%0d: got cpu/ext=%b required %b", i,
                         {cpu_gnt, ext_gnt}, {~exp_e, exp_e});
            end
            next_cycle();
        end
        n_checks++;
        if (beats !== 8) begin
            n_fail++;
            $display("FAIL burst_beats: got %0d required 8", beats);
        end
        idle();
        next_cycle();
    endtask

    task automatic test_early_release();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 30'h50, '0);
        @(negedge clk);
        n_checks++;
        if (ext_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL early_beat1: got ext_gnt=%b required 1", ext_gnt);
        end
        next_cycle();
        drive(1'b1, 1'b0, 30'h58, '0, 1'b1, 1'b0, 1'b1, 30'h51, '0);
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, ext_gnt, cpu_stall} !== 3'b011) begin
            n_fail++;
            $display("FAIL early_beat2: got cpu/ext/stall=%b required 011", {cpu_gnt, ext_gnt, cpu_stall});
        end
        next_cycle();
        drive(1'b1, 1'b0, 30'h58, '0, 1'b1, 1'b0, 1'b0, 30'h52, '0);
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, ext_gnt} !== 2'b01 || dut.beat_cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL early_beat3: got cpu/ext=%b beat_cnt=%0d required 01 beat_cnt=2",
                     {cpu_gnt, ext_gnt}, dut.beat_cnt);
        end
        next_cycle();
        drive(1'b1, 1'b0, 30'h58, '0, 1'b1, 1'b0, 1'b0, 30'h53, '0);
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, ext_gnt} !== 2'b10 || dut.beat_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL early_release: got cpu/ext=%b beat_cnt=%0d required 10 beat_cnt=0",
                     {cpu_gnt, ext_gnt}, dut.beat_cnt);
        end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 30'h4, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        n_checks++;
        if (cpu_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_cpu_gnt: got %b required 1", cpu_gnt);
        end
        next_cycle();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 30'h8, '0);
        @(negedge clk);
        n_checks++;
        if ({ext_gnt, cpu_rvalid, ext_rvalid} !== 3'b110 || cpu_rdata !== mem_init(4) ||
            ext_rdata !== '0) begin
            n_fail++;
            $display("FAIL b2b_cpu_ret: got g/cv/ev=%b cd=%h ed=%h required 110 cd=%h ed=0",
                     {ext_gnt, cpu_rvalid, ext_rvalid}, cpu_rdata, ext_rdata, mem_init(4));
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if ({cpu_rvalid, ext_rvalid} !== 2'b01 || ext_rdata !== mem_init(8) || cpu_rdata !== '0) begin
            n_fail++;
            $display("FAIL b2b_ext_ret: got cv/ev=%b cd=%h ed=%h required 01 cd=0 ed=%h",
                     {cpu_rvalid, ext_rvalid}, cpu_rdata, ext_rdata, mem_init(8));
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 30'h70, '0);
        @(negedge clk);
        n_checks++;
        if (ext_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_burst_b1: got %b required 1", ext_gnt);
        end
        next_cycle();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 30'h71, '0);
        @(negedge clk);
        n_checks++;
        if (ext_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_burst_b2: got %b required 1", ext_gnt);
        end
        @(posedge clk);
        #2;
        n_checks++;
        if ({ext_rvalid, ext_gnt} !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_inflight: got ev/eg=%b required 11", {ext_rvalid, ext_gnt});
        end
        drive(1'b1, 1'b0, 30'h72, '0, 1'b1, 1'b0, 1'b1, 30'h73, '0);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, mem_read_en, mem_w_en} !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_async: got %b required 000000",
                     {cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, mem_read_en, mem_w_en});
        end
        n_checks++;
        if (ext_rdata !== '0) begin
            n_fail++;
            $display("FAIL rst_rdata: got %h required 0", ext_rdata);
        end
        @(posedge clk);
        drive(1'b1, 1'b0, 30'h72, '0, 1'b1, 1'b0, 1'b0, 30'h73, '0);
        #2 reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, ext_gnt, ext_rvalid, cpu_rvalid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL rst_after_cpu_first: got cg/eg/ev/cv=%b required 1000",
                     {cpu_gnt, ext_gnt, ext_rvalid, cpu_rvalid});
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== mem_init(32'h72)) begin
            n_fail++;
            $display("FAIL rst_after_read: got v=%b d=%h required v=1 d=%h",
                     cpu_rvalid, cpu_rdata, mem_init(32'h72));
        end
        next_cycle();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        mem_rdata = '0;
        idle();
        for (int i = 0; i < 256; i++) mem[i] = mem_init(i);
        fork
            mem_model();
            monitor();
        join_none

        test_reset();
        test_cpu_only();
        test_contention();
        test_burst();
        test_early_release();
        test_back_to_back();
        test_reset_mid_burst();

        idle();
        repeat (3) next_cycle();
        @(negedge clk);
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_drained: got %0d pending required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
